// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: decodes PS/2 scan-code bytes into a press-ordered set of up to three held keys.
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   clr         synchronous active-high reset
//   byte_in     scan-code byte from the PS/2 receiver
//   byte_valid  byte_in holds an unconsumed byte (level)
//   byte_ack    one-cycle pulse after a byte is consumed
//   key0..key2  held key codes, oldest first, 8'h00 when the slot is empty
//   state       number of held keys, 0..3
//   overflow    sticky flag: a make arrived while three keys were held
//
// Optional feature: define KEYTRK_TIMEOUT_EN to release all keys after
// TIMEOUT_CYCLES idle cycles with keys held (guards against lost break codes).
module ps2_key_tracker #(
    parameter logic [7:0]  BREAK_CODE     = 8'hF0,
    parameter logic [7:0]  EXT_CODE       = 8'hE0,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ack,
    output logic [7:0] key0,
    output logic [7:0] key1,
    output logic [7:0] key2,
    output logic [1:0] state,
    output logic       overflow
);
    typedef enum logic [1:0] {IDLE, BRK, EXT, EXTBRK} dec_t;

    dec_t        dec_q;
    logic [23:0] slots_q, slots_d;
    logic [1:0]  state_q, state_d;
    logic        ack_q, ovf_q, ovf_d;
    logic        accept, is_make, is_break, expire, hit;
    logic [1:0]  hit_idx;
    logic [23:0] low_mask;

    // byte_valid is ignored during the ack cycle, capping throughput at one byte per two cycles
    assign accept   = byte_valid && !ack_q;
    assign is_make  = accept && dec_q == IDLE && byte_in != BREAK_CODE && byte_in != EXT_CODE && byte_in != 8'h00;
    assign is_break = accept && dec_q == BRK;

    always_comb begin
        hit     = 1'b0;
        hit_idx = 2'd0;
        // only occupied slots may match, so a break of 00 never hits an empty slot
        for (int i = 0; i < 3; i++) begin
            if (!hit && i < int'(state_q) && slots_q[8*i +: 8] == byte_in) begin
                hit     = 1'b1;
                hit_idx = 2'(i);
            end
        end
        // bits below the released slot stay, everything above slides down one byte
        low_mask = (24'h1 << {hit_idx, 3'b000}) - 24'h1;
        slots_d  = slots_q;
        state_d  = state_q;
        ovf_d    = ovf_q;
        if (is_make && !hit) begin
            if (state_q == 2'd3) begin
                ovf_d = 1'b1;
            end else begin
                slots_d = slots_q | ({16'h0, byte_in} << {state_q, 3'b000});
                state_d = state_q + 2'd1;
            end
        end
        if (is_break && hit) begin
            slots_d = (slots_q & low_mask) | ((slots_q >> 8) & ~low_mask);
            state_d = state_q - 2'd1;
        end
    end

`ifdef KEYTRK_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] idle_q;

    // idle_q counts consecutive non-accepting edges with keys held; expiry fires on the TIMEOUT_CYCLES-th
    assign expire = !accept && state_q != 2'd0 && idle_q == CW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (clr || accept || state_q == 2'd0 || expire) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_q + CW'(1);
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            dec_q   <= IDLE;
            slots_q <= '0;
            state_q <= '0;
            ack_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            ack_q <= accept;
            if (accept) begin
                slots_q <= slots_d;
                state_q <= state_d;
                ovf_q   <= ovf_d;
                case (dec_q)
                    IDLE:    dec_q <= byte_in == BREAK_CODE ? BRK : byte_in == EXT_CODE ? EXT : IDLE;
                    EXT:     dec_q <= byte_in == BREAK_CODE ? EXTBRK : IDLE;
                    default: dec_q <= IDLE;
                endcase
            end else if (expire) begin
                slots_q <= '0;
                state_q <= '0;
                dec_q   <= IDLE;
            end
        end
    end

    assign byte_ack = ack_q;
    assign key0     = slots_q[7:0];
    assign key1     = slots_q[15:8];
    assign key2     = slots_q[23:16];
    assign state    = state_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker: randomized and directed check of ps2_key_tracker against a queue-based key-set model.
module tb_ps2_key_tracker;
    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic       byte_ack;
    logic [7:0] key0, key1, key2;
    logic [1:0] state;
    logic       overflow;

    always #5 clk = ~clk;

    ps2_key_tracker #(.TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .clr(clr), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ack(byte_ack), .key0(key0), .key1(key1), .key2(key2),
        .state(state), .overflow(overflow)
    );

    int errors = 0;
    int checks = 0;

    // inputs as seen by the DUT at the last rising edge
    logic       s_clr = 1'b1, s_valid = 1'b0;
    logic [7:0] s_byte = 8'h00;
    always @(posedge clk) begin
        s_clr   <= clr;
        s_valid <= byte_valid;
        s_byte  <= byte_in;
    end

    // model: held keys as a press-ordered queue, pending prefix as flags
    logic [7:0] held[$];
    bit pend_brk = 0, pend_ext = 0, m_ack = 0, m_ovf = 0;
    int idle_n = 0;

    task automatic model_byte(input logic [7:0] b);
        int idx[$];
        if (pend_ext) begin
            pend_ext = 0;
            pend_brk = (b == 8'hF0) && !pend_brk;
            if (pend_brk) pend_ext = 1;
            else pend_brk = 0;
            return;
        end
        if (pend_brk) begin
            pend_brk = 0;
            idx = held.find_first_index(x) with (x == b);
            if (idx.size() != 0) held.delete(idx[0]);
            return;
        end
        if (b == 8'hF0) pend_brk = 1;
        else if (b == 8'hE0) pend_ext = 1;
        else if (b != 8'h00) begin
            idx = held.find_first_index(x) with (x == b);
            if (idx.size() == 0) begin
                if (held.size() < 3) held.push_back(b);
                else m_ovf = 1;
            end
        end
    endtask

    task automatic model_step();
        bit acc;
        if (s_clr) begin
            held.delete();
            pend_brk = 0; pend_ext = 0; m_ack = 0; m_ovf = 0; idle_n = 0;
            return;
        end
        acc = s_valid && !m_ack;
        if (acc) model_byte(s_byte);
`ifdef KEYTRK_TIMEOUT_EN
        if (acc || held.size() == 0) idle_n = 0;
        else begin
            idle_n++;
            if (idle_n == 100) begin
                held.delete();
                pend_brk = 0; pend_ext = 0; idle_n = 0;
            end
        end
`endif
        m_ack = acc;
    endtask

    function automatic logic [7:0] mkey(input int i);
        return i < held.size() ? held[i] : 8'h00;
    endfunction

    int cyc = 0;
    always @(negedge clk) begin
        logic [27:0] got, exp;
        model_step();
        cyc++;
        got = {byte_ack, key0, key1, key2, state, overflow};
        exp = {m_ack, mkey(0), mkey(1), mkey(2), 2'(held.size()), m_ovf};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL cycle %0d outputs: got ack=%b keys=%h,%h,%h state=%0d ovf=%b, want ack=%b keys=%h,%h,%h state=%0d ovf=%b",
                     cyc, got[27], got[26:19], got[18:11], got[10:3], got[2:1], got[0],
                     exp[27], exp[26:19], exp[18:11], exp[10:3], exp[2:1], exp[0]);
        end
    end

    task automatic lit(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        byte_in = b;
        byte_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!byte_ack && n < 20);
        checks++;
        if (!byte_ack) begin
            errors++;
            $display("FAIL ack timeout for byte %h: got no ack, want ack within 20 cycles", b);
            byte_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        byte_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic restart();
        byte_valid = 1'b0;
        clr_pulse();
    endtask

    logic [7:0] pool[9] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h4D, 8'h00, 8'hF0, 8'hE0, 8'hF0};

    initial begin
        repeat (2) @(negedge clk);
        clr = 1'b0;
        lit("reset state", {6'h0, state}, 8'h00);
        lit("reset key0", key0, 8'h00);
        lit("reset overflow", {7'h0, overflow}, 8'h00);

        send(8'h1C); idle(2);
        lit("single make key0", key0, 8'h1C);
        lit("single make state", {6'h0, state}, 8'h01);

        restart();
        send(8'h1C); send(8'h1B); send(8'h23); send(8'hF0); send(8'h1B); idle(2);
        lit("mid break key0", key0, 8'h1C);
        lit("mid break key1", key1, 8'h23);
        lit("mid break key2", key2, 8'h00);
        lit("mid break state", {6'h0, state}, 8'h02);

        restart();
        send(8'h1C); send(8'h1B); send(8'h23); send(8'h2B); idle(2);
        lit("overflow key2", key2, 8'h23);
        lit("overflow state", {6'h0, state}, 8'h03);
        lit("overflow flag", {7'h0, overflow}, 8'h01);
        send(8'hF0); send(8'h1C); idle(2);
        lit("ovf break key0", key0, 8'h1B);
        lit("ovf break key1", key1, 8'h23);
        lit("ovf break key2", key2, 8'h00);
        lit("ovf break state", {6'h0, state}, 8'h02);
        lit("ovf sticky", {7'h0, overflow}, 8'h01);

        restart();
        send(8'h1C); send(8'h1C); send(8'hF0); send(8'h4D);
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); idle(2);
        lit("ignored key0", key0, 8'h1C);
        lit("ignored key1", key1, 8'h00);
        lit("ignored state", {6'h0, state}, 8'h01);

        restart();
        send(8'hF0); byte_valid = 1'b0; clr_pulse(); send(8'h1C); idle(2);
        lit("prefix dropped key0", key0, 8'h1C);
        lit("prefix dropped state", {6'h0, state}, 8'h01);

`ifdef KEYTRK_TIMEOUT_EN
        restart();
        send(8'h1C); idle(110);
        lit("timeout state", {6'h0, state}, 8'h00);
        lit("timeout key0", key0, 8'h00);
        send(8'h1C); idle(90); send(8'hF0); send(8'h1C); idle(2);
        lit("pre-timeout release", {6'h0, state}, 8'h00);
`endif

        restart();
        for (int n = 0; n < 600; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3) clr_pulse();
            else if (r < 18) idle($urandom_range(1, 4));
            else send(pool[$urandom_range(0, 8)]);
        end
        idle(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
